ascon_aead_ctrl: RTL and testbench

- Sequencing FSM for the Ascon-128 encryption datapath: a 320-bit state register, a one-round-per-cycle permutation, and the key/AD/PT XOR muxes.
- Issues load, permutation-enable, round-constant index and XOR-select strobes for the initialization, AD absorb, domain separation, PT encrypt and finalization phases.
- Paces the AD and PT block streams with valid/ready handshakes and flags ciphertext and tag outputs.
- Sits between the top-level encrypt wrapper and the state/permutation datapath.

---
 rtl/ascon_aead_ctrl_if.sv | 43 ++++
 rtl/ascon_aead_ctrl.sv | 138 +++++++++++++
 tb/tb_ascon_aead_ctrl.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/ascon_aead_ctrl_if.sv
// ascon_aead_ctrl_if: handshake and strobe bundle between the encrypt wrapper and
// the Ascon-128 sequencing controller.
//   start/no_ad            message start request, latched AD-absence flag
//   ad_valid/ad_last/ad_ready   AD block stream handshake
//   pt_valid/pt_last/pt_ready   PT block stream handshake
//   ld_init, perm_en, rnd_idx, key_xor_init, xor_ad, dom_sep, xor_pt, key_xor_fin
//                          datapath control strobes
//   ct_valid/tag_valid     output qualifiers; busy covers LOAD..TAG
// Modport master: the side that requests messages and observes strobes.
// Modport slave: the controller itself.
interface ascon_aead_ctrl_if;
    logic       start;
    logic       no_ad;
    logic       ad_valid;
    logic       ad_last;
    logic       ad_ready;
    logic       pt_valid;
    logic       pt_last;
    logic       pt_ready;
    logic       ld_init;
    logic       perm_en;
    logic [3:0] rnd_idx;
    logic       key_xor_init;
    logic       xor_ad;
    logic       dom_sep;
    logic       xor_pt;
    logic       key_xor_fin;
    logic       ct_valid;
    logic       tag_valid;
    logic       busy;

    modport master (
        output start, no_ad, ad_valid, ad_last, pt_valid, pt_last,
        input  ad_ready, pt_ready, ld_init, perm_en, rnd_idx, key_xor_init, xor_ad,
               dom_sep, xor_pt, key_xor_fin, ct_valid, tag_valid, busy
    );

    modport slave (
        input  start, no_ad, ad_valid, ad_last, pt_valid, pt_last,
        output ad_ready, pt_ready, ld_init, perm_en, rnd_idx, key_xor_init, xor_ad,
               dom_sep, xor_pt, key_xor_fin, ct_valid, tag_valid, busy
    );
endinterface

// File: rtl/ascon_aead_ctrl.sv
// ascon_aead_ctrl: sequencing FSM for an Ascon-128 encryption datapath with a
// one-round-per-cycle permutation. Steps through init, AD absorb, domain
// separation, PT encrypt and finalization, pacing AD/PT blocks by handshake.
// Ports:
//   CLK  rising-edge clock
//   RST  synchronous active-low reset
//   bus  ascon_aead_ctrl_if.slave: start/no_ad, AD and PT handshakes, datapath
//        strobes, ct_valid/tag_valid/busy
module ascon_aead_ctrl #(
    parameter int unsigned A_ROUNDS = 12,
    parameter int unsigned B_ROUNDS = 6
) (
    input logic              CLK,
    input logic              RST,
    ascon_aead_ctrl_if.slave bus
);

    typedef enum logic [3:0] {
        StIdle, StLoad, StInitP, StInitK, StAdWait, StAdP,
        StDsep, StPtWait, StPtP, StFinK, StFinP, StTag
    } state_e;

    // Reduced-round variants use the tail of the 12-entry constant table.
    localparam logic [3:0] ABase = 4'(12 - A_ROUNDS);
    localparam logic [3:0] BBase = 4'(12 - B_ROUNDS);
    localparam logic [3:0] ALast = 4'(A_ROUNDS - 1);
    localparam logic [3:0] BLast = 4'(B_ROUNDS - 1);

    state_e     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic       no_ad_q, no_ad_d;
    logic       ad_last_q, ad_last_d;

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_q   <= StIdle;
            cnt_q     <= 4'd0;
            no_ad_q   <= 1'b0;
            ad_last_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            no_ad_q   <= no_ad_d;
            ad_last_q <= ad_last_d;
        end
    end

    always_comb begin
        state_d          = state_q;
        cnt_d            = 4'd0;  // counter clears outside and on exit of round states
        no_ad_d          = no_ad_q;
        ad_last_d        = ad_last_q;
        bus.ad_ready     = 1'b0;
        bus.pt_ready     = 1'b0;
        bus.ld_init      = 1'b0;
        bus.perm_en      = 1'b0;
        bus.rnd_idx      = 4'd0;
        bus.key_xor_init = 1'b0;
        bus.xor_ad       = 1'b0;
        bus.dom_sep      = 1'b0;
        bus.xor_pt       = 1'b0;
        bus.key_xor_fin  = 1'b0;
        bus.ct_valid     = 1'b0;
        bus.tag_valid    = 1'b0;
        bus.busy         = (state_q != StIdle);

        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    state_d = StLoad;
                    no_ad_d = bus.no_ad;
                end
            end
            StLoad: begin
                bus.ld_init = 1'b1;
                state_d     = StInitP;
            end
            StInitP: begin
                bus.perm_en = 1'b1;
                bus.rnd_idx = ABase + cnt_q;
                if (cnt_q == ALast) state_d = StInitK;
                else                cnt_d   = cnt_q + 4'd1;
            end
            StInitK: begin
                bus.key_xor_init = 1'b1;
                state_d          = no_ad_q ? StDsep : StAdWait;
            end
            StAdWait: begin
                bus.ad_ready = 1'b1;
                if (bus.ad_valid) begin
                    bus.xor_ad = 1'b1;
                    ad_last_d  = bus.ad_last;
                    state_d    = StAdP;
                end
            end
            StAdP: begin
                bus.perm_en = 1'b1;
                bus.rnd_idx = BBase + cnt_q;
                if (cnt_q == BLast) state_d = ad_last_q ? StDsep : StAdWait;
                else                cnt_d   = cnt_q + 4'd1;
            end
            StDsep: begin
                bus.dom_sep = 1'b1;
                state_d     = StPtWait;
            end
            StPtWait: begin
                bus.pt_ready = 1'b1;
                if (bus.pt_valid) begin
                    bus.xor_pt   = 1'b1;
                    bus.ct_valid = 1'b1;
                    state_d      = bus.pt_last ? StFinK : StPtP;
                end
            end
            StPtP: begin
                bus.perm_en = 1'b1;
                bus.rnd_idx = BBase + cnt_q;
                if (cnt_q == BLast) state_d = StPtWait;
                else                cnt_d   = cnt_q + 4'd1;
            end
            StFinK: begin
                bus.key_xor_fin = 1'b1;
                state_d         = StFinP;
            end
            StFinP: begin
                bus.perm_en = 1'b1;
                bus.rnd_idx = ABase + cnt_q;
                if (cnt_q == ALast) state_d = StTag;
                else                cnt_d   = cnt_q + 4'd1;
            end
            StTag: begin
                bus.tag_valid = 1'b1;
                state_d       = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

endmodule

// File: tb/tb_ascon_aead_ctrl.sv
// tb_ascon_aead_ctrl: directed bench for ascon_aead_ctrl. Each message run logs a
// packed output word per cycle (LOAD = cycle 1); expected words come from a table
// of hand-written phase segments, plus hand checks for multi-block, stall and
// mid-message reset cases.
module tb_ascon_aead_ctrl;

    // Packed output word: {ld_init, perm_en, rnd_idx[3:0], key_xor_init, xor_ad,
    // dom_sep, xor_pt, key_xor_fin, ct_valid, tag_valid, ad_ready, pt_ready, busy}
    localparam logic [15:0] WLD   = 16'h8001;
    localparam logic [15:0] WPERM = 16'h4001;
    localparam logic [15:0] WKXI  = 16'h0201;
    localparam logic [15:0] WXAD  = 16'h0105;
    localparam logic [15:0] WDOM  = 16'h0081;
    localparam logic [15:0] WXPT  = 16'h0053;
    localparam logic [15:0] WKXF  = 16'h0021;
    localparam logic [15:0] WTAG  = 16'h0009;
    localparam logic [15:0] WPTW  = 16'h0003;
    localparam logic [15:0] WZERO = 16'h0000;

    typedef struct {
        int          scen;
        int          first;
        int          last;
        logic [15:0] exp;
        int          rnd0;
    } seg_t;

    logic clk;
    logic rst;
    ascon_aead_ctrl_if bus ();

    ascon_aead_ctrl #(
        .A_ROUNDS(12),
        .B_ROUNDS(6)
    ) dut (
        .CLK(clk),
        .RST(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    seg_t        segs[$];
    logic [15:0] trace[256];
    int          tag_cyc;
    int          ct_cyc[$];
    int          nvec = 0;
    int          nfail = 0;

    function automatic logic [15:0] outs();
        return {bus.ld_init, bus.perm_en, bus.rnd_idx, bus.key_xor_init, bus.xor_ad,
                bus.dom_sep, bus.xor_pt, bus.key_xor_fin, bus.ct_valid, bus.tag_valid,
                bus.ad_ready, bus.pt_ready, bus.busy};
    endfunction

    task automatic chk(input string name, input int c, input logic [15:0] got,
                       input logic [15:0] exp);
        nvec++;
        if (got !== exp) begin
            nfail++;
            $display("FAIL %s cycle %0d: got %h expected %h", name, c, got, exp);
        end
    endtask

    task automatic chk_int(input string name, input int got, input int exp);
        nvec++;
        if (got != exp) begin
            nfail++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic add_seg(input int s, input int f, input int l, input logic [15:0] e,
                           input int r);
        seg_t t;
        t.scen = s; t.first = f; t.last = l; t.exp = e; t.rnd0 = r;
        segs.push_back(t);
    endtask

    task automatic check_segs(input int scen, input string name);
        logic [15:0] e;
        foreach (segs[i]) begin
            if (segs[i].scen == scen) begin
                for (int c = segs[i].first; c <= segs[i].last; c++) begin
                    e = segs[i].exp;
                    if (e[14]) e[13:10] = 4'(segs[i].rnd0 + c - segs[i].first);
                    chk(name, c, trace[c], e);
                end
            end
        end
    endtask

    task automatic idle_inputs();
        bus.start = 1'b0; bus.no_ad = 1'b0;
        bus.ad_valid = 1'b0; bus.ad_last = 1'b0;
        bus.pt_valid = 1'b0; bus.pt_last = 1'b0;
    endtask

    // One message: start, then drive zero-stall streams (except stall cycles at
    // PT_WAIT), optional stray start pulse and optional reset at cycle rst_cyc.
    task automatic run_msg(input logic na, input int n_ad, input int n_pt, input int stall,
                           input int pulse_cyc, input int rst_cyc);
        int ad_sent = 0;
        int pt_sent = 0;
        int stall_left = stall;
        for (int i = 0; i < 256; i++) trace[i] = 16'hffff;
        tag_cyc = -1;
        ct_cyc.delete();
        @(negedge clk);
        idle_inputs();
        bus.start = 1'b1;
        bus.no_ad = na;
        for (int cyc = 1; cyc <= 150; cyc++) begin
            @(negedge clk);
            bus.start    = (cyc == pulse_cyc);
            rst          = !(cyc == rst_cyc);
            bus.ad_valid = (ad_sent < n_ad);
            bus.ad_last  = (ad_sent == n_ad - 1);
            bus.pt_valid = (pt_sent < n_pt);
            bus.pt_last  = (pt_sent == n_pt - 1);
            #1;
            if (stall_left > 0 && bus.pt_ready) begin
                bus.pt_valid = 1'b0;
                stall_left--;
            end
            #1;
            trace[cyc] = outs();
            if (bus.ad_valid && bus.ad_ready) ad_sent++;
            if (bus.pt_valid && bus.pt_ready) pt_sent++;
            if (bus.ct_valid) ct_cyc.push_back(cyc);
            if (bus.tag_valid) tag_cyc = cyc;
            if (tag_cyc > 0 && cyc == tag_cyc + 3) break;
            if (rst_cyc > 0 && cyc == rst_cyc + 3) break;
        end
        idle_inputs();
        rst = 1'b1;
        if (rst_cyc == 0 && tag_cyc < 0) begin
            nvec++;
            nfail++;
            $display("FAIL timeout: got no tag_valid expected one within 150 cycles");
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        // Scenario 1: one AD block, one PT block.
        add_seg(1, 1, 1, WLD, 0);    add_seg(1, 2, 13, WPERM, 0);
        add_seg(1, 14, 14, WKXI, 0); add_seg(1, 15, 15, WXAD, 0);
        add_seg(1, 16, 21, WPERM, 6); add_seg(1, 22, 22, WDOM, 0);
        add_seg(1, 23, 23, WXPT, 0); add_seg(1, 24, 24, WKXF, 0);
        add_seg(1, 25, 36, WPERM, 0); add_seg(1, 37, 37, WTAG, 0);
        add_seg(1, 38, 40, WZERO, 0);
        // Scenario 2: no AD, one PT block.
        add_seg(2, 1, 1, WLD, 0);    add_seg(2, 2, 13, WPERM, 0);
        add_seg(2, 14, 14, WKXI, 0); add_seg(2, 15, 15, WDOM, 0);
        add_seg(2, 16, 16, WXPT, 0); add_seg(2, 17, 17, WKXF, 0);
        add_seg(2, 18, 29, WPERM, 0); add_seg(2, 30, 30, WTAG, 0);
        add_seg(2, 31, 33, WZERO, 0);
        // Scenario 4: 5-cycle PT stall, stray start at cycle 5.
        add_seg(4, 1, 1, WLD, 0);    add_seg(4, 2, 13, WPERM, 0);
        add_seg(4, 14, 14, WKXI, 0); add_seg(4, 15, 15, WXAD, 0);
        add_seg(4, 16, 21, WPERM, 6); add_seg(4, 22, 22, WDOM, 0);
        add_seg(4, 23, 27, WPTW, 0); add_seg(4, 28, 28, WXPT, 0);
        add_seg(4, 29, 29, WKXF, 0); add_seg(4, 30, 41, WPERM, 0);
        add_seg(4, 42, 42, WTAG, 0); add_seg(4, 43, 45, WZERO, 0);

        // Reset held two cycles with start high.
        idle_inputs();
        rst = 1'b0;
        bus.start = 1'b1;
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("reset_outputs", 0, outs(), WZERO);
        rst = 1'b0;
        bus.start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        #1;
        chk("after_release", 0, outs(), WZERO);

        run_msg(1'b0, 1, 1, 0, 0, 0);
        check_segs(1, "ad1_pt1");

        run_msg(1'b1, 0, 1, 0, 0, 0);
        check_segs(2, "noad_pt1");

        run_msg(1'b0, 1, 6, 0, 0, 0);
        chk_int("pt6_ct_count", ct_cyc.size(), 6);
        for (int k = 0; k < 6 && k < ct_cyc.size(); k++)
            chk_int("pt6_ct_cycle", ct_cyc[k], 23 + 7 * k);
        chk_int("pt6_tag_cycle", tag_cyc, 72);
        chk("pt6_trace_fink", 59, trace[59], WKXF);

        run_msg(1'b0, 1, 1, 5, 5, 0);
        check_segs(4, "pt_stall");

        // Reset inside AD_P (cycle 20 is round 4 of p^b: rnd_idx 10).
        run_msg(1'b0, 3, 1, 0, 0, 20);
        chk("rst_before", 20, trace[20], WPERM | 16'h2800);
        for (int c = 21; c <= 23; c++) chk("rst_after", c, trace[c], WZERO);
        chk_int("rst_no_tag", tag_cyc, -1);

        run_msg(1'b0, 1, 1, 0, 0, 0);
        check_segs(1, "rerun_after_rst");

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
